// File: rtl/cpx_div_iter_pkg.sv
// Shared defaults and FSM encoding for the iterative complex divider.
// Operands are packed {real, imag}, each component signed with FRAC_BITS fractional bits.
package cpx_div_iter_pkg;

  localparam int DEF_CPX_SIZE  = 74;
  localparam int DEF_HALF_SIZE = 37;
  localparam int DEF_FRAC_BITS = 24;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PREP = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/cpx_div_iter_udiv_step_iter.sv
// Unsigned restoring divider, one quotient bit per step, MSB first.
// The dividend must be below divisor << QW so that the quotient fits in QW bits.
module udiv_step_iter #(
  parameter int NW = 99,
  parameter int DW = 75,
  parameter int QW = 36
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          step,
  input  logic [NW-1:0] dividend,
  input  logic [DW-1:0] divisor,
  output logic [QW-1:0] quotient
);

  localparam int SW = DW + QW - 1;
  localparam int CW = (NW > SW) ? NW : SW;

  logic [CW-1:0] rem;
  logic [CW-1:0] dsh;
  logic          fits;

  assign fits = (rem >= dsh);

  // dsh starts at divisor << (QW-1) and walks down one bit position per step
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem      <= '0;
      dsh      <= '0;
      quotient <= '0;
    end else if (load) begin
      rem      <= CW'(dividend);
      dsh      <= CW'({divisor, {(QW-1){1'b0}}});
      quotient <= '0;
    end else if (step) begin
      if (fits) begin
        rem <= rem - dsh;
      end
      quotient <= {quotient[QW-2:0], fits};
      dsh      <= dsh >> 1;
    end
  end

endmodule

// File: rtl/cpx_div_iter.sv
// Iterative fixed-point complex divider: C = A * conj(B) / |B|^2, one division in flight.
// Quotient magnitudes truncate toward zero; out-of-range components saturate symmetrically.
module cpx_div_iter
  import cpx_div_iter_pkg::*;
#(
  parameter int CPX_SIZE  = DEF_CPX_SIZE,
  parameter int HALF_SIZE = DEF_HALF_SIZE,
  parameter int FRAC_BITS = DEF_FRAC_BITS
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [CPX_SIZE-1:0] cpx_A,
  input  logic [CPX_SIZE-1:0] cpx_B,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [CPX_SIZE-1:0] cpx_C,
  output logic                div_zero,
  output logic                sat
);

  localparam int PW    = 2 * HALF_SIZE + 1;
  localparam int QW    = HALF_SIZE - 1;
  localparam int NW    = PW + FRAC_BITS;
  localparam int CW    = PW + QW;
  localparam int CNT_W = $clog2(QW + 1);

  // Handshake: a transfer happens on a rising edge where valid && ready are both high.
  // in_ready is high only in IDLE; out_valid holds with stable data until out_ready.

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [CPX_SIZE-1:0] a_r;
  logic [CPX_SIZE-1:0] b_r;
  logic               neg_re, neg_im;
  logic               ovf_re, ovf_im;
  logic               zero_f;

  logic signed [PW-1:0] ar, ai, br, bi;
  logic signed [PW-1:0] nr, ni, dd;
  logic        [PW-1:0] d_mag, mag_re, mag_im;
  logic        [NW-1:0] num_re, num_im;
  logic                 ovf_re_c, ovf_im_c;
  logic        [QW-1:0] q_re, q_im;
  logic                 div_load, div_step;

  assign ar = PW'($signed(a_r[CPX_SIZE-1:HALF_SIZE]));
  assign ai = PW'($signed(a_r[HALF_SIZE-1:0]));
  assign br = PW'($signed(b_r[CPX_SIZE-1:HALF_SIZE]));
  assign bi = PW'($signed(b_r[HALF_SIZE-1:0]));

  // Full-precision numerator of A*conj(B) and the shared denominator |B|^2
  assign nr    = ar * br + ai * bi;
  assign ni    = ai * br - ar * bi;
  assign dd    = br * br + bi * bi;
  assign d_mag = $unsigned(dd);

  assign mag_re = nr[PW-1] ? $unsigned(-nr) : $unsigned(nr);
  assign mag_im = ni[PW-1] ? $unsigned(-ni) : $unsigned(ni);
  assign num_re = {mag_re, {FRAC_BITS{1'b0}}};
  assign num_im = {mag_im, {FRAC_BITS{1'b0}}};

  // Quotient magnitude would need more than QW bits
  assign ovf_re_c = (CW'(num_re) >= {d_mag, {QW{1'b0}}});
  assign ovf_im_c = (CW'(num_im) >= {d_mag, {QW{1'b0}}});

  assign div_load = (state == ST_PREP);
  assign div_step = (state == ST_DIV) && (cnt != CNT_W'(QW));

  udiv_step_iter #(.NW(NW), .DW(PW), .QW(QW)) u_div_re (
    .clk      (clk),
    .rst      (rst),
    .load     (div_load),
    .step     (div_step),
    .dividend (num_re),
    .divisor  (d_mag),
    .quotient (q_re)
  );

  udiv_step_iter #(.NW(NW), .DW(PW), .QW(QW)) u_div_im (
    .clk      (clk),
    .rst      (rst),
    .load     (div_load),
    .step     (div_step),
    .dividend (num_im),
    .divisor  (d_mag),
    .quotient (q_im)
  );

  function automatic logic [HALF_SIZE-1:0] fmt_comp(input logic [QW-1:0] q,
                                                    input logic          neg,
                                                    input logic          ovf);
    logic [HALF_SIZE-1:0] m;
    m = ovf ? {1'b0, {QW{1'b1}}} : {1'b0, q};
    return neg ? -m : m;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      a_r       <= '0;
      b_r       <= '0;
      neg_re    <= 1'b0;
      neg_im    <= 1'b0;
      ovf_re    <= 1'b0;
      ovf_im    <= 1'b0;
      zero_f    <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      cpx_C     <= '0;
      div_zero  <= 1'b0;
      sat       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            a_r      <= cpx_A;
            b_r      <= cpx_B;
            in_ready <= 1'b0;
            state    <= ST_PREP;
          end
        end
        ST_PREP: begin
          neg_re <= nr[PW-1];
          neg_im <= ni[PW-1];
          ovf_re <= ovf_re_c;
          ovf_im <= ovf_im_c;
          zero_f <= (d_mag == '0);
          cnt    <= '0;
          state  <= ST_DIV;
        end
        ST_DIV: begin
          // The cycle after the last quotient bit formats the result
          if (cnt == CNT_W'(QW)) begin
            state     <= ST_DONE;
            out_valid <= 1'b1;
            div_zero  <= zero_f;
            sat       <= !zero_f && (ovf_re || ovf_im);
            cpx_C     <= zero_f ? '0 : {fmt_comp(q_re, neg_re, ovf_re),
                                        fmt_comp(q_im, neg_im, ovf_im)};
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
